serial_sub: RTL
===============

Name: serial_sub

Overview:
Bit-serial subtractor, the inverse operation of the team's ripple adder datapath. It computes D = A − B − bin over W clock cycles, LSB first, using a single one-bit full-subtractor cell and a borrow flip-flop. Operands are accepted with a start/busy/done handshake. It sits beside the parallel adder in area-constrained paths where latency is acceptable.

Parameters:
W, 8, operand and result width in bits (legal range 2..32)
CW, $clog2(W), bit-index counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  W  minuend; captured on the accepting edge
b  input  W  subtrahend; captured on the accepting edge
bin  input  1  borrow-in; captured on the accepting edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; d/bout valid and stable
d  output  W  difference result register
bout  output  1  borrow-out (1 means A < B + bin, unsigned)

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, d=0, bout=0, internal shift registers/counter/borrow=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge captures a→sa, b→sb, bin→borrow reg, sets count=0, next state RUN. If start=0, the FSM stays in IDLE.
- RUN: each edge processes one bit, LSB first.
  - diff bit = sa[0]^sb[0]^borrow
  - borrow' = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow)
  - sa and sb shift right by 1. The diff bit shifts into the MSB of the working register sd.
  - count increments.
- Completion: on the edge where count==W−1, d←final sd (all W bits, bit0=first processed), bout←borrow', next state DONE.
- busy=1 exactly in RUN, for W cycles.
- DONE: done=1 for exactly one cycle. Next edge goes to IDLE, or, if start=1 on that edge, captures new operands and goes directly to RUN (back-to-back; no idle bubble required).
- Latency: start accepted at edge k → done high in the cycle after edge k+W. Throughput is one result per W+1 cycles.
- start while busy is ignored. a/b/bin changes during RUN have no effect.
- d and bout change only at the transition into DONE and on reset. They hold between operations.
- Arithmetic is unsigned modulo 2^W: d = (a − b − bin) mod 2^W, bout = (a < b + bin).
- Reset mid-RUN: immediate return to reset values. No done pulse, and the partial result is discarded.
- No X propagation. Counter compares against W−1 exactly; unused count codes are unreachable.

Decomposition:
- Shared package serial_arith_pkg:
  - state typedef (IDLE/RUN/DONE) as a 2-bit enum
  - localparam default width 8
- One natural sub-module: fsub_bit, a combinational one-bit full subtractor (inputs x, y, bi; outputs d, bo). It is instantiated once in serial_sub and is reusable for a future parallel ripple subtractor.

Test Plan:
- Reset then a=8'h5A, b=8'h3C, bin=0, start pulse → busy high 8 cycles, done pulse, d=8'h1E, bout=0.
- a=8'h00, b=8'h01, bin=0 → d=8'hFF, bout=1. Then a=8'h10, b=8'h10, bin=1 → d=8'hFF, bout=1.
- a=8'hFF, b=8'h00, bin=1 → d=8'hFE, bout=0. During RUN, toggle start and change a/b to 8'h00 → result unaffected, no restart.
- Back-to-back: hold start=1 through the DONE cycle with a=8'h80, b=8'h7F → second op starts with no IDLE cycle, d=8'h01, bout=0. The first result stays stable until the second DONE.
- Drive rst_n=0 asynchronously mid-RUN (count=3) → busy, done, d, bout go to 0 immediately. After release, a new op completes correctly.
- Random 1000 ops at W=8 and W=16 against the reference model (a−b−bin) → d and bout exact. done count equals accepted start count.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_fsub_bit.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit borrows.
module fsub_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference and borrow of a single bit position.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - bin over W cycles, LSB first, one
// full-subtractor cell plus a borrow flop, start/busy/done handshake.
module serial_sub
  import serial_arith_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bout
);

  localparam int CW = $clog2(W);

  state_e        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  sd_q, sd_d;
  logic          borrow_q, borrow_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  d_q, d_d;
  logic          bout_q, bout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          diff_bit;
  logic          borrow_nxt;
  logic [W-1:0]  sd_shift;

  // The single subtractor cell, fed by the LSBs of the working operands.
  fsub_bit u_cell (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .bi (borrow_q),
    .d  (diff_bit),
    .bo (borrow_nxt)
  );

  assign sd_shift = {diff_bit, sd_q[W-1:1]};

  // Next-state logic: operand capture, per-bit shift, and completion.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    d_d      = d_q;
    bout_d   = bout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts start as well, so back-to-back ops need no bubble.
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = bin;
          sd_d     = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        sd_d     = sd_shift;
        borrow_d = borrow_nxt;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(W - 1)) begin
          // Last bit: publish the full word and the final borrow.
          d_d     = sd_shift;
          bout_d  = borrow_nxt;
          count_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // All state and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;

endmodule
